ctrl_pipe_chain: RTL and testbench

CTRL_PIPE_CHAIN -- requirements
Module: ctrl_pipe_chain

---
 rtl/ctrl_pipe_pkg.sv | 19 +
 rtl/ctrl_pipe_chain_slot.sv | 76 +++++++
 rtl/ctrl_pipe_chain.sv | 101 ++++++++++
 tb/tb_ctrl_pipe_chain.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control pipeline chain: default field widths,
// the NOP opcode and the per-stage control record.
package ctrl_pipe_pkg;

    localparam int DEF_OP_W = 7;
    localparam int DEF_F3_W = 3;
    localparam int DEF_RD_W = 5;

    localparam logic [DEF_OP_W-1:0] OP_NOP = '0;

    typedef struct packed {
        logic                valid;
        logic [DEF_OP_W-1:0] op;
        logic [DEF_F3_W-1:0] f3;
        logic [DEF_RD_W-1:0] rd;
        logic                we;
    } stage_t;

endpackage

// File: rtl/ctrl_pipe_chain_slot.sv
// One control stage: loads a new record, holds it, or clears it.
// Payload fields are forced to zero whenever the stage is not valid.
module ctrl_pipe_slot
    import ctrl_pipe_pkg::*;
#(
    parameter int OP_W = DEF_OP_W,
    parameter int F3_W = DEF_F3_W,
    parameter int RD_W = DEF_RD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic            valid_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [F3_W-1:0] f3_i,
    input  logic [RD_W-1:0] rd_i,
    input  logic            we_i,
    output logic            valid_o,
    output logic [OP_W-1:0] op_o,
    output logic [F3_W-1:0] f3_o,
    output logic [RD_W-1:0] rd_o,
    output logic            we_o
);

    logic            valid_q, valid_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [F3_W-1:0] f3_q, f3_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            we_q, we_d;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        we_d    = we_q;
        if (clear_i) begin
            valid_d = 1'b0;
            op_d    = OP_W'(OP_NOP);
            f3_d    = '0;
            rd_d    = '0;
            we_d    = 1'b0;
        end else if (load_i) begin
            // A bubble carries no payload so downstream sees all-zero fields.
            valid_d = valid_i;
            op_d    = valid_i ? op_i : OP_W'(OP_NOP);
            f3_d    = valid_i ? f3_i : '0;
            rd_d    = valid_i ? rd_i : '0;
            we_d    = valid_i & we_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_q    <= OP_W'(OP_NOP);
            f3_q    <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign f3_o    = f3_q;
    assign rd_o    = rd_q;
    assign we_o    = we_q;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// In-order control pipeline of DEPTH stages with stall/flush, per-stage
// register-hazard match vectors and an occupancy count.
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OP_W  = DEF_OP_W,
    parameter int F3_W  = DEF_F3_W,
    parameter int RD_W  = DEF_RD_W,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_op,
    input  logic [F3_W-1:0]  in_f3,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_we,
    input  logic             stall,
    input  logic             flush,
    input  logic [RD_W-1:0]  rs1,
    input  logic [RD_W-1:0]  rs2,
    output logic             out_valid,
    output logic [OP_W-1:0]  out_op,
    output logic [F3_W-1:0]  out_f3,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_we,
    output logic [DEPTH-1:0] hit_rs1,
    output logic [DEPTH-1:0] hit_rs2,
    output logic [OCC_W-1:0] occ
);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("ctrl_pipe_chain: DEPTH must be within 1..8");
    end

    logic [DEPTH-1:0]           s_valid, s_we, src_valid, src_we;
    logic [DEPTH-1:0][OP_W-1:0] s_op, src_op;
    logic [DEPTH-1:0][F3_W-1:0] s_f3, src_f3;
    logic [DEPTH-1:0][RD_W-1:0] s_rd, src_rd;
    logic                       advance;

    // Flush outranks stall; stall freezes every stage and drops the inputs.
    assign advance = ~stall & ~flush;

    always_comb begin
        src_valid[0] = in_valid;
        src_op[0]    = in_op;
        src_f3[0]    = in_f3;
        src_rd[0]    = in_rd;
        src_we[0]    = in_we;
        for (int k = 1; k < DEPTH; k++) begin
            src_valid[k] = s_valid[k-1];
            src_op[k]    = s_op[k-1];
            src_f3[k]    = s_f3[k-1];
            src_rd[k]    = s_rd[k-1];
            src_we[k]    = s_we[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        ctrl_pipe_slot #(
            .OP_W (OP_W),
            .F3_W (F3_W),
            .RD_W (RD_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (advance),
            .clear_i (flush),
            .valid_i (src_valid[k]),
            .op_i    (src_op[k]),
            .f3_i    (src_f3[k]),
            .rd_i    (src_rd[k]),
            .we_i    (src_we[k]),
            .valid_o (s_valid[k]),
            .op_o    (s_op[k]),
            .f3_o    (s_f3[k]),
            .rd_o    (s_rd[k]),
            .we_o    (s_we[k])
        );
    end

    always_comb begin
        hit_rs1 = '0;
        hit_rs2 = '0;
        occ     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit_rs1[k] = s_valid[k] & s_we[k] & (s_rd[k] == rs1) & (rs1 != '0);
            hit_rs2[k] = s_valid[k] & s_we[k] & (s_rd[k] == rs2) & (rs2 != '0);
            occ        = occ + OCC_W'(s_valid[k]);
        end
    end

    assign out_valid = s_valid[DEPTH-1];
    assign out_op    = s_op[DEPTH-1];
    assign out_f3    = s_f3[DEPTH-1];
    assign out_rd    = s_rd[DEPTH-1];
    assign out_we    = s_we[DEPTH-1];

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Bench for ctrl_pipe_chain: four depths share one stimulus stream and are
// compared every cycle against a queue-based reference model.
module tb_ctrl_pipe_chain;

    localparam int NG = 4;
    localparam int DEPTHS [NG] = '{1, 2, 3, 8};

    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic [2:0] f3;
        logic [4:0] rd;
        logic       we;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] in_op = '0;
    logic [2:0] in_f3 = '0;
    logic [4:0] in_rd = '0;
    logic       in_we = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] rs1 = '0;
    logic [4:0] rs2 = '0;

    wire       w_valid [NG];
    wire [6:0] w_op    [NG];
    wire [2:0] w_f3    [NG];
    wire [4:0] w_rd    [NG];
    wire       w_we    [NG];
    wire [7:0] w_h1    [NG];
    wire [7:0] w_h2    [NG];
    wire [3:0] w_occ   [NG];

    int n_checks = 0;
    int n_err    = 0;

    ent_t mq [NG][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NG; g++) begin : g_dut
        localparam int D  = DEPTHS[g];
        localparam int OW = $clog2(D + 1);
        wire [D-1:0]  h1, h2;
        wire [OW-1:0] oc;
        ctrl_pipe_chain #(.DEPTH(D)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_op     (in_op),
            .in_f3     (in_f3),
            .in_rd     (in_rd),
            .in_we     (in_we),
            .stall     (stall),
            .flush     (flush),
            .rs1       (rs1),
            .rs2       (rs2),
            .out_valid (w_valid[g]),
            .out_op    (w_op[g]),
            .out_f3    (w_f3[g]),
            .out_rd    (w_rd[g]),
            .out_we    (w_we[g]),
            .hit_rs1   (h1),
            .hit_rs2   (h2),
            .occ       (oc)
        );
        assign w_h1[g]  = 8'(h1);
        assign w_h2[g]  = 8'(h2);
        assign w_occ[g] = 4'(oc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int g = 0; g < NG; g++) begin
            mq[g].delete();
            for (int k = 0; k < DEPTHS[g]; k++) mq[g].push_back('0);
        end
    endtask

    // Reference: a pipe of fixed length; advancing pushes the new entry in at
    // the head and the oldest entry falls off the tail.
    task automatic mdl_edge();
        ent_t e;
        if (flush) begin
            mdl_reset();
        end else if (!stall) begin
            e = in_valid ? ent_t'{1'b1, in_op, in_f3, in_rd, in_we} : ent_t'('0);
            for (int g = 0; g < NG; g++) begin
                mq[g].push_front(e);
                void'(mq[g].pop_back());
            end
        end
    endtask

    task automatic check_all(input string ph);
        ent_t o;
        int   cnt;
        logic [7:0] eh1, eh2;
        for (int g = 0; g < NG; g++) begin
            o   = mq[g][DEPTHS[g]-1];
            cnt = 0;
            eh1 = '0;
            eh2 = '0;
            for (int k = 0; k < DEPTHS[g]; k++) begin
                if (mq[g][k].v) cnt++;
                eh1[k] = mq[g][k].v && mq[g][k].we && mq[g][k].rd == rs1 && rs1 != 0;
                eh2[k] = mq[g][k].v && mq[g][k].we && mq[g][k].rd == rs2 && rs2 != 0;
            end
            chk($sformatf("%s d%0d out_valid", ph, DEPTHS[g]), 32'(w_valid[g]), 32'(o.v));
            chk($sformatf("%s d%0d out_op", ph, DEPTHS[g]),    32'(w_op[g]),    32'(o.op));
            chk($sformatf("%s d%0d out_f3", ph, DEPTHS[g]),    32'(w_f3[g]),    32'(o.f3));
            chk($sformatf("%s d%0d out_rd", ph, DEPTHS[g]),    32'(w_rd[g]),    32'(o.rd));
            chk($sformatf("%s d%0d out_we", ph, DEPTHS[g]),    32'(w_we[g]),    32'(o.we));
            chk($sformatf("%s d%0d occ", ph, DEPTHS[g]),       32'(w_occ[g]),   32'(cnt));
            chk($sformatf("%s d%0d hit_rs1", ph, DEPTHS[g]),   32'(w_h1[g]),    32'(eh1));
            chk($sformatf("%s d%0d hit_rs2", ph, DEPTHS[g]),   32'(w_h2[g]),    32'(eh2));
        end
    endtask

    task automatic step(input string ph, input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic we, input logic st, input logic fl,
                        input logic [4:0] r1, input logic [4:0] r2);
        in_valid = v;
        in_op    = op;
        in_f3    = f3;
        in_rd    = rd;
        in_we    = we;
        stall    = st;
        flush    = fl;
        rs1      = r1;
        rs2      = r2;
        @(posedge clk);
        mdl_edge();
        #1;
        check_all(ph);
    endtask

    task automatic bubble(input string ph);
        step(ph, 1'b0, 7'h0, 3'h0, 5'h0, 1'b0, 1'b0, 1'b0, 5'h0, 5'h0);
    endtask

    initial begin
        mdl_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single instruction through DEPTH=3: occupancy 1 for three cycles.
        step("lat", 1'b1, 7'h33, 3'h0, 5'd5, 1'b1, 1'b0, 1'b0, 5'h0, 5'h0);
        chk("lat occ c1", 32'(w_occ[2]), 32'd1);
        bubble("lat");
        chk("lat occ c2", 32'(w_occ[2]), 32'd1);
        chk("lat early out_valid", 32'(w_valid[2]), 32'd0);
        bubble("lat");
        chk("lat occ c3", 32'(w_occ[2]), 32'd1);
        chk("lat out_valid c3", 32'(w_valid[2]), 32'd1);
        chk("lat out_rd c3", 32'(w_rd[2]), 32'd5);
        chk("lat out_op c3", 32'(w_op[2]), 32'h33);
        bubble("lat");

        // Hold an entry in S1 of DEPTH=2 under a four-cycle stall.
        step("stl", 1'b1, 7'h13, 3'h2, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 5'h0);
        bubble("stl");
        for (int i = 0; i < 4; i++) begin
            step("stl", 1'b1, 7'($urandom), 3'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b0, 5'd5, 5'h0);
            chk("stl out_valid", 32'(w_valid[1]), 32'd1);
            chk("stl out_op", 32'(w_op[1]), 32'h13);
            chk("stl out_f3", 32'(w_f3[1]), 32'h2);
            chk("stl out_rd", 32'(w_rd[1]), 32'd5);
            chk("stl hit_rs1", 32'(w_h1[1]), 32'b10);
            chk("stl occ", 32'(w_occ[1]), 32'd1);
        end

        // Fill DEPTH=3 then flush with stall also high.
        step("fl", 1'b1, 7'h03, 3'h1, 5'd1, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3);
        step("fl", 1'b1, 7'h23, 3'h2, 5'd2, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3);
        step("fl", 1'b1, 7'h63, 3'h3, 5'd3, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3);
        chk("fl full occ", 32'(w_occ[2]), 32'd3);
        chk("fl full hit_rs1", 32'(w_h1[2]), 32'b010);
        step("fl", 1'b1, 7'h6f, 3'h4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd2, 5'd3);
        chk("fl occ", 32'(w_occ[2]), 32'd0);
        chk("fl out_valid", 32'(w_valid[2]), 32'd0);
        chk("fl out_op", 32'(w_op[2]), 32'd0);
        chk("fl out_rd", 32'(w_rd[2]), 32'd0);
        chk("fl hit_rs1", 32'(w_h1[2]), 32'd0);
        chk("fl hit_rs2", 32'(w_h2[2]), 32'd0);

        // Hazard corner cases on the DEPTH=1 instance.
        step("hz", 1'b1, 7'h33, 3'h0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("hz rd0 hit_rs1", 32'(w_h1[0]), 32'd0);
        step("hz", 1'b1, 7'h33, 3'h0, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7);
        chk("hz we0 hit_rs2", 32'(w_h2[0]), 32'd0);
        step("hz", 1'b1, 7'h33, 3'h0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 5'd7);
        chk("hz match hit_rs2", 32'(w_h2[0]), 32'd1);

        // Asynchronous reset at a random phase in the middle of traffic.
        for (int i = 0; i < 5; i++)
            step("pre", 1'b1, 7'($urandom), 3'($urandom), 5'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0, 5'd3, 5'd4);
        @(posedge clk);
        mdl_edge();
        #($urandom_range(1, 8));
        rst = 1'b1;
        mdl_reset();
        #1;
        for (int g = 0; g < NG; g++) begin
            chk($sformatf("arst d%0d out_valid", DEPTHS[g]), 32'(w_valid[g]), 32'd0);
            chk($sformatf("arst d%0d out_rd", DEPTHS[g]), 32'(w_rd[g]), 32'd0);
            chk($sformatf("arst d%0d occ", DEPTHS[g]), 32'(w_occ[g]), 32'd0);
            chk($sformatf("arst d%0d hits", DEPTHS[g]), 32'({w_h1[g], w_h2[g]}), 32'd0);
        end
        check_all("arst");
        @(negedge clk);
        rst = 1'b0;
        step("rel", 1'b1, 7'h37, 3'h5, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 5'h0);
        for (int i = 2; i <= 8; i++) begin
            bubble("rel");
            if (i == 3) begin
                chk("rel d3 out_valid", 32'(w_valid[2]), 32'd1);
                chk("rel d3 out_rd", 32'(w_rd[2]), 32'd9);
            end
            if (i == 7) chk("rel d8 early out_valid", 32'(w_valid[3]), 32'd0);
            if (i == 8) begin
                chk("rel d8 out_valid", 32'(w_valid[3]), 32'd1);
                chk("rel d8 out_op", 32'(w_op[3]), 32'h37);
            end
        end

        // Random regression across all depths.
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), 7'($urandom), 3'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 15) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
